// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: FSM state encodings, owner IDs
// and the default access timeout.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// Access timeout counter: clears while clr_i is high, counts while en_i is
// high, and flags the last allowed ACCESS cycle on tc_o.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count value is the number of ACCESS cycles already completed.
  assign tc_o = (cnt_q == CW'(LIMIT - 1));

  // Next count: clear has priority, stop once terminal count is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data load/store.
// One access in flight at a time; data requests win over fetch requests.
// Optional feature macro: MEM_TIMEOUT_EN (abort an access after
// TIMEOUT_CYCLES ACCESS cycles, acking it with err=1 and rdata=0).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              cs,
  output logic              we,
  output logic              oe,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  input  logic              ram_ready
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;
  logic              oe_q, oe_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef MEM_TIMEOUT_EN
  logic err_q, err_d;
  logic tmo_tc;

  mem_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .clr_i(state_q != ST_ACCESS),
    .en_i (state_q == ST_ACCESS),
    .tc_o (tmo_tc)
  );

  assign err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

  // Next-state and registered-output logic; we_q doubles as the latched store flag.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cs_d      = cs_q;
    we_d      = we_q;
    oe_d      = oe_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    if_ack_d  = 1'b0;
    d_ack_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (d_req) begin
          state_d   = ST_ACCESS;
          owner_d   = OWN_DATA;
          address_d = d_addr;
          wdata_d   = d_wdata;
          cs_d      = 1'b1;
          we_d      = d_we;
          oe_d      = ~d_we;
        end else if (if_req) begin
          state_d   = ST_ACCESS;
          owner_d   = OWN_FETCH;
          address_d = if_addr;
          cs_d      = 1'b1;
          we_d      = 1'b0;
          oe_d      = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (ram_ready) begin
          state_d  = ST_RESP;
          cs_d     = 1'b0;
          we_d     = 1'b0;
          oe_d     = 1'b0;
          if (!we_q) begin
            rdata_d = ram_data_out;
          end
          if_ack_d = (owner_q == OWN_FETCH);
          d_ack_d  = (owner_q == OWN_DATA);
`ifdef MEM_TIMEOUT_EN
        end else if (tmo_tc) begin
          state_d  = ST_RESP;
          cs_d     = 1'b0;
          we_d     = 1'b0;
          oe_d     = 1'b0;
          rdata_d  = '0;
          err_d    = 1'b1;
          if_ack_d = (owner_q == OWN_FETCH);
          d_ack_d  = (owner_q == OWN_DATA);
`endif
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        oe_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any in-flight access without an ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_FETCH;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      oe_q      <= 1'b0;
      if_ack_q  <= 1'b0;
      d_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
      address_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cs_q      <= cs_d;
      we_q      <= we_d;
      oe_q      <= oe_d;
      if_ack_q  <= if_ack_d;
      d_ack_q   <= d_ack_d;
      busy_q    <= busy_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
`ifdef MEM_TIMEOUT_EN
      err_q     <= err_d;
`endif
    end
  end

  assign cs          = cs_q;
  assign we          = we_q;
  assign oe          = oe_q;
  assign if_ack      = if_ack_q;
  assign d_ack       = d_ack_q;
  assign busy        = busy_q;
  assign address     = address_q;
  assign ram_data_in = wdata_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a scoreboard of expected
// transactions and a small wait-state RAM model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
  logic        cs;
  logic        we;
  logic        oe;
  logic [31:0] address;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;
  logic        ram_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_data;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } txn_t;

  txn_t sb[$];

  logic [31:0] mem [0:255];
  int          wcnt;
  int          wait_cycles;
  logic        tie_ready;
  logic        ready_en;
  logic [31:0] model_rdata;
  logic        prev_ack;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_ack      (if_ack),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ack       (d_ack),
    .rdata       (rdata),
    .err         (err),
    .busy        (busy),
    .cs          (cs),
    .we          (we),
    .oe          (oe),
    .address     (address),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out),
    .ram_ready   (ram_ready)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 64) return 32'hE3A0_1005;
    return 32'hC0DE_0000 | i;
  endfunction

  // RAM model: ready after wait_cycles ACCESS cycles (or always when tied)
  assign ram_ready    = tie_ready | (ready_en & cs & (wcnt >= wait_cycles));
  assign ram_data_out = mem[address[9:2]];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      wcnt <= 0;
    end else begin
      wcnt <= cs ? wcnt + 1 : 0;
      if (cs && we && ram_ready) mem[address[9:2]] <= ram_data_in;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_d, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input logic e);
    txn_t t;
    t.is_data = is_d;
    t.wr      = wr;
    t.addr    = a;
    t.wdata   = wd;
    t.rdata   = rd;
    t.err     = e;
    sb.push_back(t);
  endtask

  // Wait for an ack (bounded); lat counts negedges, -1 on expiry.
  task automatic wait_ack(input int maxc, output int cs_n, output int lat);
    int n;
    cs_n = 0;
    n    = 0;
    lat  = -1;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      n++;
      if (cs) cs_n++;
      if (if_ack || d_ack) begin
        if (d_ack) d_req = 1'b0;
        if (if_ack) if_req = 1'b0;
        lat = n;
        break;
      end
    end
  endtask

  // Scoreboard monitor: checks RAM-side signals and every ack against the queue.
  always @(negedge clk) begin
    txn_t t;
    if (!rst) begin
      sb.delete();
      model_rdata = '0;
      prev_ack    = 1'b0;
    end else begin
      if (prev_ack) check("idle_gap_cs", cs, 0);
      if (cs) begin
        check("cs_has_txn", sb.size() != 0, 1);
        check("busy_in_access", busy, 1);
        check("no_ack_in_access", if_ack | d_ack, 0);
        if (sb.size() != 0) begin
          check("address", address, sb[0].addr);
          check("we", we, sb[0].wr);
          check("oe", oe, !sb[0].wr);
          if (sb[0].wr) check("ram_data_in", ram_data_in, sb[0].wdata);
        end
      end
      if (if_ack || d_ack) begin
        check("ack_has_txn", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          t = sb.pop_front();
          check("ack_owner", {if_ack, d_ack}, t.is_data ? 2'b01 : 2'b10);
          if (!t.wr) model_rdata = t.rdata;
          check("rdata", rdata, model_rdata);
          check("err", err, t.err);
        end
      end else begin
        check("err_no_ack", err, 0);
      end
      prev_ack = if_ack | d_ack;
    end
  end

  initial begin
    int          csn;
    int          lat;
    int          busy_cnt;
    logic [31:0] la [3];
    logic [31:0] lv [3];

    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; tie_ready = 1'b0; ready_en = 1'b1; wait_cycles = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", cs, 0);
    check("rst_we", we, 0);
    check("rst_oe", oe, 0);
    check("rst_if_ack", if_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_address", address, 0);
    check("rst_ram_data_in", ram_data_in, 0);
    check("rst_rdata", rdata, 0);

    // Reset in the middle of a stalled load
    @(posedge clk); #1;
    rst = 1'b1; ready_en = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    push(1'b1, 1'b0, 32'h40, '0, init_val(16), 1'b0);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; ready_en = 1'b1;
    @(negedge clk);
    check("t1_cs", cs, 0);
    check("t1_busy", busy, 0);
    check("t1_rdata", rdata, 0);
    check("t1_d_ack", d_ack, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_no_ack", if_ack | d_ack, 0);
    end

    // Fetch alone with two RAM wait cycles
    wait_cycles = 2;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_0100;
    push(1'b0, 1'b0, 32'h100, '0, 32'hE3A0_1005, 1'b0);
    wait_ack(20, csn, lat);
    check("t2_cs_cycles", csn, 3);
    check("t2_latency", lat, 5);
    check("t2_rdata", rdata, 32'hE3A0_1005);

    // Collision: store wins, fetch follows
    wait_cycles = 1;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_0104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'h1234_5678;
    push(1'b1, 1'b1, 32'h200, 32'h1234_5678, '0, 1'b0);
    push(1'b0, 1'b0, 32'h104, '0, 32'hC0DE_0041, 1'b0);
    wait_ack(20, csn, lat);
    check("t3_store_latency", lat, 4);
    check("t3_store_cs", csn, 2);
    check("t3_fetch_pending", if_req, 1);
    d_we = 1'b0;
    wait_ack(20, csn, lat);
    check("t3_fetch_latency", lat, 4);
    check("t3_fetch_cs", csn, 2);

    // Zero-wait RAM, back-to-back loads
    tie_ready = 1'b1;
    la[0] = 32'h10;  lv[0] = 32'hC0DE_0004;
    la[1] = 32'h14;  lv[1] = 32'hC0DE_0005;
    la[2] = 32'h200; lv[2] = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      d_req = 1'b1; d_we = 1'b0; d_addr = la[i];
      push(1'b1, 1'b0, la[i], '0, lv[i], 1'b0);
      wait_ack(20, csn, lat);
      check("t4_latency", lat, 3);
      check("t4_cs", csn, 1);
    end
    check("t4_rdata_store_readback", rdata, 32'h1234_5678);
    tie_ready = 1'b0;

    // Request dropped after one cycle still completes
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    push(1'b1, 1'b0, 32'h20, '0, 32'hC0DE_0008, 1'b0);
    @(posedge clk); #1;
    d_req = 1'b0;
    wait_ack(20, csn, lat);
    check("t5_latency", lat, 3);
    check("t5_cs", csn, 2);

    // RAM never ready
    @(posedge clk); #1;
    ready_en = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
`ifdef MEM_TIMEOUT_EN
    push(1'b1, 1'b0, 32'h30, '0, 32'h0, 1'b1);
    wait_ack(30, csn, lat);
    check("t6_cs_cycles", csn, 4);
    check("t6_latency", lat, 6);
    check("t6_rdata", rdata, 0);
    check("t6_err", err, 1);
    ready_en = 1'b1;
`else
    push(1'b1, 1'b0, 32'h30, '0, init_val(12), 1'b0);
    busy_cnt = 0;
    @(posedge clk); #1;
    d_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("t6_busy_held", busy_cnt, 50);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; ready_en = 1'b1;
    @(negedge clk);
    check("t6_busy_after_rst", busy, 0);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
